rsa_power_requester: RTL and testbench

- Initiator side of the rsa_top power handshake. It drives rsa_top's req_enable/req_disable/start and watches rsa_top's ready/done.
- Powers mod_exp up on demand when the host has a job pending.
- Issues the start pulse once mod_exp reports ready.
- Requests power-down after a programmable idle period.
- Sits in PD_top, beside rsa_top, between the host job interface and rsa_top.

---
 rtl/rsa_power_requester_pkg.sv | 25 ++
 rtl/rsa_power_requester.sv | 129 ++++++++++++
 tb/tb_rsa_power_requester.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_power_requester_pkg.sv
// Shared types and helpers for the rsa_top power requester.
// State encoding and counter width derivation.
package rsa_power_requester_pkg;

  typedef enum logic [2:0] {
    S_UP_WAIT,
    S_ON_IDLE,
    S_ON_BUSY,
    S_DOWN_WAIT,
    S_OFF
  } state_t;

  function automatic int cnt_width(
    input int idle_t,
    input int ack_t,
    input int guard_t
  );
    int m;
    m = idle_t;
    if (ack_t > m) m = ack_t;
    if (guard_t > m) m = guard_t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rsa_power_requester.sv
// Initiator side of the rsa_top power handshake: powers mod_exp up on
// demand, issues start once ready, and powers down after an idle period.
module rsa_power_requester
  import rsa_power_requester_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 64,
  parameter int ACK_TIMEOUT  = 256,
  parameter int DOWN_GUARD   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic job_valid,
  output logic job_accept,
  output logic job_done,
  output logic start,
  output logic req_enable,
  output logic req_disable,
  input  logic ready,
  input  logic done,
  input  logic err_clr,
  output logic power_on,
  output logic busy,
  output logic err_timeout
);

  localparam int CNT_W =
    cnt_width(IDLE_TIMEOUT, ACK_TIMEOUT, DOWN_GUARD);

  localparam logic [CNT_W-1:0] IDLE_LAST =
    CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ACK_LAST =
    CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST =
    CNT_W'(DOWN_GUARD - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // saturating increment of the shared counter
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_UP_WAIT;
      cnt         <= '0;
      start       <= 1'b0;
      job_accept  <= 1'b0;
      job_done    <= 1'b0;
      req_enable  <= 1'b0;
      req_disable <= 1'b0;
      power_on    <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else if (ce) begin
      start       <= 1'b0;
      job_accept  <= 1'b0;
      job_done    <= 1'b0;
      req_enable  <= 1'b0;
      req_disable <= 1'b0;
      if (err_clr) err_timeout <= 1'b0;
      unique case (state)
        S_UP_WAIT: begin
          if (ready) begin
            state    <= S_ON_IDLE;
            power_on <= 1'b1;
            cnt      <= '0;
          end else if (cnt == ACK_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_OFF;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_ON_IDLE: begin
          // a pending job always beats the idle timeout
          if (job_valid && ready) begin
            start      <= 1'b1;
            job_accept <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ON_BUSY;
            cnt        <= '0;
          end else if (!job_valid) begin
            if (cnt == IDLE_LAST) begin
              req_disable <= 1'b1;
              power_on    <= 1'b0;
              state       <= S_DOWN_WAIT;
              cnt         <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_ON_BUSY: begin
          if (done) begin
            job_done <= 1'b1;
            busy     <= 1'b0;
            state    <= S_ON_IDLE;
            cnt      <= '0;
          end
        end
        S_DOWN_WAIT: begin
          if (ready) begin
            cnt <= '0;
          end else if (cnt == GUARD_LAST) begin
            state <= S_OFF;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_OFF: begin
          if (job_valid) begin
            req_enable <= 1'b1;
            state      <= S_UP_WAIT;
            cnt        <= '0;
          end
        end
        default: begin
          state <= S_UP_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_power_requester.sv
// Bench for rsa_power_requester: directed walk through the power cycle,
// then randomized traffic against an emulated rsa_top and host.
module tb_rsa_power_requester;

  localparam int IDLE = 8;
  localparam int ACK  = 16;
  localparam int GRD  = 4;

  logic clk;
  logic rst_n;
  logic ce;
  logic job_valid;
  logic job_accept;
  logic job_done;
  logic start;
  logic req_enable;
  logic req_disable;
  logic ready;
  logic done;
  logic err_clr;
  logic power_on;
  logic busy;
  logic err_timeout;

  rsa_power_requester #(
    .IDLE_TIMEOUT(IDLE),
    .ACK_TIMEOUT (ACK),
    .DOWN_GUARD  (GRD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .job_valid  (job_valid),
    .job_accept (job_accept),
    .job_done   (job_done),
    .start      (start),
    .req_enable (req_enable),
    .req_disable(req_disable),
    .ready      (ready),
    .done       (done),
    .err_clr    (err_clr),
    .power_on   (power_on),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: phase of the power cycle plus elapsed ce-cycles
  localparam int P_UP   = 0;
  localparam int P_IDLE = 1;
  localparam int P_BUSY = 2;
  localparam int P_DOWN = 3;
  localparam int P_OFF  = 4;

  int phase;
  int elapsed;
  bit m_start, m_acc, m_jd, m_re, m_rd, m_pwr, m_busy, m_err;

  function automatic void model_reset();
    phase   = P_UP;
    elapsed = 0;
    m_start = 0; m_acc = 0; m_jd = 0; m_re = 0; m_rd = 0;
    m_pwr   = 0; m_busy = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    if (!ce) return;
    m_start = 0; m_acc = 0; m_jd = 0; m_re = 0; m_rd = 0;
    if (err_clr) m_err = 0;
    case (phase)
      P_UP: begin
        if (ready) begin
          phase = P_IDLE; m_pwr = 1; elapsed = 0;
        end else begin
          elapsed++;
          if (elapsed >= ACK) begin
            m_err = 1; phase = P_OFF; elapsed = 0;
          end
        end
      end
      P_IDLE: begin
        if (job_valid && ready) begin
          m_start = 1; m_acc = 1; m_busy = 1;
          phase = P_BUSY; elapsed = 0;
        end else if (!job_valid) begin
          elapsed++;
          if (elapsed >= IDLE) begin
            m_rd = 1; m_pwr = 0; phase = P_DOWN; elapsed = 0;
          end
        end
      end
      P_BUSY: begin
        if (done) begin
          m_jd = 1; m_busy = 0; phase = P_IDLE; elapsed = 0;
        end
      end
      P_DOWN: begin
        if (ready) elapsed = 0;
        else begin
          elapsed++;
          if (elapsed >= GRD) begin
            phase = P_OFF; elapsed = 0;
          end
        end
      end
      default: begin
        if (job_valid) begin
          m_re = 1; phase = P_UP; elapsed = 0;
        end
      end
    endcase
  endfunction

  task automatic cmp_all();
    chk("start", 32'(start), 32'(m_start));
    chk("job_accept", 32'(job_accept), 32'(m_acc));
    chk("job_done", 32'(job_done), 32'(m_jd));
    chk("req_enable", 32'(req_enable), 32'(m_re));
    chk("req_disable", 32'(req_disable), 32'(m_rd));
    chk("power_on", 32'(power_on), 32'(m_pwr));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    chk("req_excl", 32'(req_enable & req_disable), 32'(0));
  endtask

  task automatic cyc(
    input logic c,
    input logic jv,
    input logic rdy,
    input logic dn,
    input logic clr
  );
    ce = c; job_valid = jv; ready = rdy; done = dn; err_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  // emulated rsa_top and host
  int  e_pwr;
  int  e_cnt;
  bit  e_job;
  int  e_dcnt;
  bit  e_done;
  bit  h_jv;
  bit  p_re, p_rd, p_st, p_ja, p_jd;

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    @(posedge clk);
    #1;
    cmp_all();
    rst_n = 1'b1;
    e_pwr = ($urandom_range(0, 1) == 1) ? 2 : 0;
    e_cnt = 0; e_job = 0; e_dcnt = 0; e_done = 0; h_jv = 0;
    p_re = 0; p_rd = 0; p_st = 0; p_ja = 0; p_jd = 0;
  endtask

  task automatic emu_update();
    if (req_enable && !p_re) begin
      e_pwr = 1; e_cnt = $urandom_range(0, 22);
    end
    if (req_disable && !p_rd) begin
      e_pwr = 3; e_cnt = $urandom_range(0, 5);
    end
    if (start && !p_st) begin
      e_job = 1; e_dcnt = $urandom_range(1, 12);
    end
    if (job_done && !p_jd) begin
      e_done = 0; e_job = 0;
    end
    if (job_accept && !p_ja) h_jv = 0;
    else if (!h_jv) h_jv = ($urandom_range(0, 9) == 0);
    if (e_pwr == 1) begin
      if (e_cnt == 0) e_pwr = 2; else e_cnt--;
    end else if (e_pwr == 3) begin
      if (e_cnt == 0) e_pwr = 0; else e_cnt--;
    end
    if (e_job && !e_done) begin
      if (e_dcnt <= 1) e_done = 1; else e_dcnt--;
    end
    p_re = req_enable; p_rd = req_disable; p_st = start;
    p_ja = job_accept; p_jd = job_done;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; ce = 1'b0; job_valid = 1'b0;
    ready = 1'b0; done = 1'b0; err_clr = 1'b0;
    model_reset();
    #3;
    cmp_all();
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp_all();
    rst_n = 1'b1;

    // power-up: ready shows up on the third cycle
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    // job with done after 20 cycles
    cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    // idle timeout, slow ready drop, guard period
    for (int i = 0; i < IDLE; i++) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < GRD; i++) cyc(1, 0, 0, 0, 0);
    // job from off, ack never comes
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < ACK; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    // frozen with ce low: no timeout, pulse held
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 0);
    // job arrives on the last idle cycle
    for (int i = 0; i < IDLE - 1; i++) cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);
    // reset with a job in flight
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);

    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc(1'($urandom_range(0, 4) != 0), h_jv,
          e_pwr == 2 || e_pwr == 3, e_done,
          1'($urandom_range(0, 19) == 0));
      emu_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
